// File: rtl/issue_pair_queue_pkg.sv
// Shared widths, ALU opcode boundary and the per-instruction micro-op record
// used by the dual-issue pair queue and its pairing checker.
`default_nettype none

package issue_pair_queue_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ISSUE_W        = 2;

    // Opcodes at or above this value are the multi-cycle mul/div class.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL = 4'd10;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]   aluop;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [1:0]                rsen;
        logic                      ldst;
        logic                      br;
    } uop_t;

    function automatic logic is_muldiv(input logic [ALU_OP_WIDTH-1:0] op);
        return (op >= ALU_MUL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_pair_queue_check.sv
// Pairing rules for two program-ordered candidates: h0 (older) and h1 (younger).
// Purely combinational; validity of the candidates is handled by the caller.
`default_nettype none

module issue_pair_check
    import issue_pair_queue_pkg::*;
(
    input  uop_t h0_i,
    input  uop_t h1_i,
    output logic pair_ok_o
);

    logic w_h0_writes;
    logic w_raw_rs1;
    logic w_raw_rs2;
    logic w_waw;
    logic w_struct_block;
    logic w_muldiv_clash;

    // x0 is never a real destination, so it can create no hazard.
    assign w_h0_writes    = (h0_i.rd != '0);
    assign w_raw_rs1      = h1_i.rsen[0] && (h1_i.rs1 == h0_i.rd);
    assign w_raw_rs2      = h1_i.rsen[1] && (h1_i.rs2 == h0_i.rd);
    assign w_waw          = (h1_i.rd == h0_i.rd);
    assign w_struct_block = h0_i.ldst || h0_i.br;
    assign w_muldiv_clash = is_muldiv(h0_i.aluop) && is_muldiv(h1_i.aluop);

    assign pair_ok_o = !w_struct_block
                    && !w_muldiv_clash
                    && !(w_h0_writes && (w_raw_rs1 || w_raw_rs2 || w_waw));

endmodule

`default_nettype wire

// File: rtl/issue_pair_queue.sv
// Decoded-instruction circular queue feeding the registered dual-issue slot
// pair; only legal pairs leave together, program order is always preserved.
`default_nettype none

module issue_pair_queue
    import issue_pair_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int PC_W  = DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      ex_hold,
    input  logic [ISSUE_W-1:0]        dec_valid,
    output logic                      dec_ready,
    input  logic [ALU_OP_WIDTH-1:0]   dec_aluop_0,
    input  logic [ALU_OP_WIDTH-1:0]   dec_aluop_1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd_0,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd_1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_0,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_0,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_1,
    input  logic [1:0]                dec_rsen_0,
    input  logic [1:0]                dec_rsen_1,
    input  logic                      dec_ldst_0,
    input  logic                      dec_ldst_1,
    input  logic                      dec_br_0,
    input  logic                      dec_br_1,
    input  logic [PC_W-1:0]           dec_pc_0,
    input  logic [PC_W-1:0]           dec_pc_1,
    output logic [ISSUE_W-1:0]        iss_valid,
    output logic [ALU_OP_WIDTH-1:0]   iss_aluop_0,
    output logic [ALU_OP_WIDTH-1:0]   iss_aluop_1,
    output logic [REG_ADDR_WIDTH-1:0] iss_rd_0,
    output logic [REG_ADDR_WIDTH-1:0] iss_rd_1,
    output logic [REG_ADDR_WIDTH-1:0] iss_rs1_0,
    output logic [REG_ADDR_WIDTH-1:0] iss_rs1_1,
    output logic [REG_ADDR_WIDTH-1:0] iss_rs2_0,
    output logic [REG_ADDR_WIDTH-1:0] iss_rs2_1,
    output logic [1:0]                iss_rsen_0,
    output logic [1:0]                iss_rsen_1,
    output logic                      iss_ldst_0,
    output logic                      iss_ldst_1,
    output logic                      iss_br_0,
    output logic                      iss_br_1,
    output logic [PC_W-1:0]           iss_pc_0,
    output logic [PC_W-1:0]           iss_pc_1
);

    localparam logic [PTR_W:0]   CNT_ZERO  = '0;
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   READY_MAX = (PTR_W+1)'(DEPTH-2);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Queue storage and pointers
    uop_t            mem_q    [DEPTH];
    logic [PC_W-1:0] pc_mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Issue registers
    logic [ISSUE_W-1:0] iss_valid_q, iss_valid_d;
    uop_t               iss_uop0_q, iss_uop0_d;
    uop_t               iss_uop1_q, iss_uop1_d;
    logic [PC_W-1:0]    iss_pc0_q, iss_pc0_d;
    logic [PC_W-1:0]    iss_pc1_q, iss_pc1_d;

    uop_t             dec_uop_0, dec_uop_1;
    uop_t             h0, h1;
    logic [PC_W-1:0]  h0_pc, h1_pc;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic             h0_vld, h1_vld;
    logic             pair_rules_ok, pair_ok;
    logic             enq, enq_two, issue_en;
    logic [PTR_W:0]   enq_n, deq_n;

    assign dec_uop_0 = '{aluop: dec_aluop_0, rd: dec_rd_0, rs1: dec_rs1_0, rs2: dec_rs2_0,
                         rsen: dec_rsen_0, ldst: dec_ldst_0, br: dec_br_0};
    assign dec_uop_1 = '{aluop: dec_aluop_1, rd: dec_rd_1, rs1: dec_rs1_1, rs2: dec_rs2_1,
                         rsen: dec_rsen_1, ldst: dec_ldst_1, br: dec_br_1};

    assign head_p1 = head_q + PTR_ONE;
    assign tail_p1 = tail_q + PTR_ONE;
    assign h0      = mem_q[head_q];
    assign h1      = mem_q[head_p1];
    assign h0_pc   = pc_mem_q[head_q];
    assign h1_pc   = pc_mem_q[head_p1];
    assign h0_vld  = (count_q >= CNT_ONE);
    assign h1_vld  = (count_q >= CNT_TWO);

    issue_pair_check u_pair_check (
        .h0_i      (h0),
        .h1_i      (h1),
        .pair_ok_o (pair_rules_ok)
    );

    assign pair_ok = h1_vld && pair_rules_ok;

    // Readiness looks only at the current occupancy; a same-cycle dequeue is not credited.
    assign dec_ready = (count_q <= READY_MAX);
    assign enq       = dec_ready && dec_valid[0] && !flush;
    assign enq_two   = enq && dec_valid[1];
    assign issue_en  = !ex_hold && !flush;

    always_comb begin
        enq_n = CNT_ZERO;
        if (enq_two) begin
            enq_n = CNT_TWO;
        end else if (enq) begin
            enq_n = CNT_ONE;
        end

        deq_n = CNT_ZERO;
        if (issue_en) begin
            if (pair_ok) begin
                deq_n = CNT_TWO;
            end else if (h0_vld) begin
                deq_n = CNT_ONE;
            end
        end
    end

    always_comb begin
        head_d  = head_q + deq_n[PTR_W-1:0];
        tail_d  = tail_q + enq_n[PTR_W-1:0];
        count_d = count_q + enq_n - deq_n;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_ZERO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read once count covers it.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q]    <= dec_uop_0;
            pc_mem_q[tail_q] <= dec_pc_0;
        end
        if (enq_two) begin
            mem_q[tail_p1]    <= dec_uop_1;
            pc_mem_q[tail_p1] <= dec_pc_1;
        end
    end

    // An empty slot keeps its stale payload but always presents a nop opcode.
    always_comb begin
        iss_valid_d      = iss_valid_q;
        iss_uop0_d       = iss_uop0_q;
        iss_uop1_d       = iss_uop1_q;
        iss_pc0_d        = iss_pc0_q;
        iss_pc1_d        = iss_pc1_q;
        if (flush) begin
            iss_valid_d      = '0;
            iss_uop0_d.aluop = '0;
            iss_uop1_d.aluop = '0;
        end else if (!ex_hold) begin
            iss_valid_d = {pair_ok, h0_vld};
            if (h0_vld) begin
                iss_uop0_d = h0;
                iss_pc0_d  = h0_pc;
            end else begin
                iss_uop0_d.aluop = '0;
            end
            if (pair_ok) begin
                iss_uop1_d = h1;
                iss_pc1_d  = h1_pc;
            end else begin
                iss_uop1_d.aluop = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= '0;
            iss_uop0_q  <= '0;
            iss_uop1_q  <= '0;
            iss_pc0_q   <= '0;
            iss_pc1_q   <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_uop0_q  <= iss_uop0_d;
            iss_uop1_q  <= iss_uop1_d;
            iss_pc0_q   <= iss_pc0_d;
            iss_pc1_q   <= iss_pc1_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_aluop_0 = iss_uop0_q.aluop;
    assign iss_aluop_1 = iss_uop1_q.aluop;
    assign iss_rd_0    = iss_uop0_q.rd;
    assign iss_rd_1    = iss_uop1_q.rd;
    assign iss_rs1_0   = iss_uop0_q.rs1;
    assign iss_rs1_1   = iss_uop1_q.rs1;
    assign iss_rs2_0   = iss_uop0_q.rs2;
    assign iss_rs2_1   = iss_uop1_q.rs2;
    assign iss_rsen_0  = iss_uop0_q.rsen;
    assign iss_rsen_1  = iss_uop1_q.rsen;
    assign iss_ldst_0  = iss_uop0_q.ldst;
    assign iss_ldst_1  = iss_uop1_q.ldst;
    assign iss_br_0    = iss_uop0_q.br;
    assign iss_br_1    = iss_uop1_q.br;
    assign iss_pc_0    = iss_pc0_q;
    assign iss_pc_1    = iss_pc1_q;

    // A lone slot-1 valid has no meaning to the decoder handshake.
    always @(posedge clk) begin
        if (!rst) begin
            assert (dec_valid != 2'b10)
                else $error("issue_pair_queue: dec_valid=2'b10 is not a legal decode pattern");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_pair_queue.sv
// Directed plus randomized stimulus for issue_pair_queue, checked against a
// queue-based reference model of the pairing and issue rules.
`default_nettype none

module tb_issue_pair_queue;
    import issue_pair_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  rsen;
        logic        ldst;
        logic        br;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, ex_hold;
    logic [1:0]  dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_aluop_0, dec_aluop_1;
    logic [4:0]  dec_rd_0, dec_rd_1, dec_rs1_0, dec_rs1_1, dec_rs2_0, dec_rs2_1;
    logic [1:0]  dec_rsen_0, dec_rsen_1;
    logic        dec_ldst_0, dec_ldst_1, dec_br_0, dec_br_1;
    logic [31:0] dec_pc_0, dec_pc_1;
    logic [1:0]  iss_valid;
    logic [3:0]  iss_aluop_0, iss_aluop_1;
    logic [4:0]  iss_rd_0, iss_rd_1, iss_rs1_0, iss_rs1_1, iss_rs2_0, iss_rs2_1;
    logic [1:0]  iss_rsen_0, iss_rsen_1;
    logic        iss_ldst_0, iss_ldst_1, iss_br_0, iss_br_1;
    logic [31:0] iss_pc_0, iss_pc_1;

    always #5 clk = ~clk;

    issue_pair_queue #(.DEPTH(4), .PTR_W(2), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_aluop_0(dec_aluop_0), .dec_aluop_1(dec_aluop_1),
        .dec_rd_0(dec_rd_0), .dec_rd_1(dec_rd_1),
        .dec_rs1_0(dec_rs1_0), .dec_rs1_1(dec_rs1_1),
        .dec_rs2_0(dec_rs2_0), .dec_rs2_1(dec_rs2_1),
        .dec_rsen_0(dec_rsen_0), .dec_rsen_1(dec_rsen_1),
        .dec_ldst_0(dec_ldst_0), .dec_ldst_1(dec_ldst_1),
        .dec_br_0(dec_br_0), .dec_br_1(dec_br_1),
        .dec_pc_0(dec_pc_0), .dec_pc_1(dec_pc_1),
        .iss_valid(iss_valid),
        .iss_aluop_0(iss_aluop_0), .iss_aluop_1(iss_aluop_1),
        .iss_rd_0(iss_rd_0), .iss_rd_1(iss_rd_1),
        .iss_rs1_0(iss_rs1_0), .iss_rs1_1(iss_rs1_1),
        .iss_rs2_0(iss_rs2_0), .iss_rs2_1(iss_rs2_1),
        .iss_rsen_0(iss_rsen_0), .iss_rsen_1(iss_rsen_1),
        .iss_ldst_0(iss_ldst_0), .iss_ldst_1(iss_ldst_1),
        .iss_br_0(iss_br_0), .iss_br_1(iss_br_1),
        .iss_pc_0(iss_pc_0), .iss_pc_1(iss_pc_1)
    );

    // Reference model: program-ordered list of waiting instructions plus the issued slots.
    ent_t       model_q[$];
    ent_t       exp0, exp1;
    logic [1:0] exp_valid;
    int         checks = 0;
    int         errors = 0;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    function automatic ent_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [1:0] rsen, input logic ld,
                                input logic br, input logic [31:0] pc);
        ent_t e;
        e.aluop = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.rsen = rsen; e.ldst = ld; e.br = br; e.pc = pc;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.aluop = 4'($urandom_range(0, 15));
        e.rd    = 5'($urandom_range(0, 7));
        e.rs1   = 5'($urandom_range(0, 7));
        e.rs2   = 5'($urandom_range(0, 7));
        e.rsen  = 2'($urandom_range(0, 3));
        e.ldst  = ($urandom_range(0, 5) == 0);
        e.br    = ($urandom_range(0, 5) == 0);
        e.pc    = $urandom;
        return e;
    endfunction

    // Can the younger instruction b travel in the same cycle as the older a?
    function automatic bit may_pair(input ent_t a, input ent_t b);
        if (a.ldst || a.br) return 0;
        if (a.aluop >= ALU_MUL && b.aluop >= ALU_MUL) return 0;
        if (a.rd != 5'd0) begin
            if (b.rsen[0] && b.rs1 == a.rd) return 0;
            if (b.rsen[1] && b.rs2 == a.rd) return 0;
            if (b.rd == a.rd) return 0;
        end
        return 1;
    endfunction

    task automatic drive(input logic [1:0] dv, input ent_t a, input ent_t b);
        dec_valid   = dv;
        dec_aluop_0 = a.aluop; dec_rd_0 = a.rd; dec_rs1_0 = a.rs1; dec_rs2_0 = a.rs2;
        dec_rsen_0  = a.rsen;  dec_ldst_0 = a.ldst; dec_br_0 = a.br; dec_pc_0 = a.pc;
        dec_aluop_1 = b.aluop; dec_rd_1 = b.rd; dec_rs1_1 = b.rs1; dec_rs2_1 = b.rs2;
        dec_rsen_1  = b.rsen;  dec_ldst_1 = b.ldst; dec_br_1 = b.br; dec_pc_1 = b.pc;
    endtask

    task automatic compare_iss(input string tag);
        check({tag, "/iss_valid"}, 64'(iss_valid), 64'(exp_valid));
        check({tag, "/aluop0"}, 64'(iss_aluop_0), 64'(exp0.aluop));
        check({tag, "/aluop1"}, 64'(iss_aluop_1), 64'(exp1.aluop));
        if (exp_valid[0]) begin
            check({tag, "/slot0"}, {iss_rd_0, iss_rs1_0, iss_rs2_0, iss_rsen_0, iss_ldst_0, iss_br_0},
                  {exp0.rd, exp0.rs1, exp0.rs2, exp0.rsen, exp0.ldst, exp0.br});
            check({tag, "/pc0"}, 64'(iss_pc_0), 64'(exp0.pc));
        end
        if (exp_valid[1]) begin
            check({tag, "/slot1"}, {iss_rd_1, iss_rs1_1, iss_rs2_1, iss_rsen_1, iss_ldst_1, iss_br_1},
                  {exp1.rd, exp1.rs1, exp1.rs2, exp1.rsen, exp1.ldst, exp1.br});
            check({tag, "/pc1"}, 64'(iss_pc_1), 64'(exp1.pc));
        end
    endtask

    // One clock cycle: apply inputs, check readiness, advance model and DUT, check slots.
    task automatic step(input string tag, input logic [1:0] dv, input logic hold,
                        input logic fl, input ent_t a, input ent_t b);
        bit rdy;
        int n;
        drive(dv, a, b);
        ex_hold = hold;
        flush   = fl;
        #1;
        rdy = (model_q.size() <= DEPTH - 2);
        check({tag, "/dec_ready"}, 64'(dec_ready), 64'(rdy));
        if (fl) begin
            model_q.delete();
            exp_valid  = 2'b00;
            exp0.aluop = '0;
            exp1.aluop = '0;
        end else begin
            if (!hold) begin
                n = model_q.size();
                if (n >= 1) begin exp0 = model_q[0]; exp_valid[0] = 1'b1; end
                else begin exp0.aluop = '0; exp_valid[0] = 1'b0; end
                if (n >= 2 && may_pair(model_q[0], model_q[1])) begin
                    exp1 = model_q[1]; exp_valid[1] = 1'b1;
                end else begin
                    exp1.aluop = '0; exp_valid[1] = 1'b0;
                end
                if (exp_valid[0]) void'(model_q.pop_front());
                if (exp_valid[1]) void'(model_q.pop_front());
            end
            if (rdy && dv[0]) begin
                model_q.push_back(a);
                if (dv[1]) model_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        compare_iss(tag);
    endtask

    task automatic idle(input string tag, input logic hold);
        step(tag, 2'b00, hold, 1'b0, '0, '0);
    endtask

    task automatic pair_then_drain(input string tag, input ent_t a, input ent_t b);
        step({tag, "_enq"}, 2'b11, 1'b0, 1'b0, a, b);
        idle({tag, "_iss1"}, 1'b0);
        idle({tag, "_iss2"}, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        drive(2'b00, '0, '0);
        model_q.delete();
        exp0 = '0; exp1 = '0; exp_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        compare_iss("reset");
        check("reset/dec_ready", 64'(dec_ready), 64'd1);
        rst = 1'b0;

        // Build a burst, then reset asynchronously with three entries waiting
        step("burst_a", 2'b11, 1'b0, 1'b0, mk(OP_ADD, 1, 2, 3, 2'b11, 0, 0, 32'h100), mk(OP_SUB, 4, 5, 6, 2'b11, 0, 0, 32'h104));
        idle("burst_iss", 1'b0);
        step("burst_b", 2'b11, 1'b1, 1'b0, mk(OP_ADD, 9, 2, 3, 2'b11, 0, 0, 32'h108), mk(OP_SUB, 10, 5, 6, 2'b11, 0, 0, 32'h10c));
        step("burst_c", 2'b01, 1'b1, 1'b0, mk(OP_ADD, 11, 2, 3, 2'b11, 0, 0, 32'h110), '0);
        check("pre_reset/dec_ready", 64'(dec_ready), 64'd0);
        drive(2'b00, '0, '0);
        ex_hold = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp0 = '0; exp1 = '0; exp_valid = 2'b00;
        compare_iss("async_reset");
        check("async_reset/pc0", 64'(iss_pc_0), 64'd0);
        check("async_reset/dec_ready", 64'(dec_ready), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Independent pair; lands two edges after it is presented
        step("indep_enq", 2'b11, 1'b0, 1'b0, mk(OP_ADD, 1, 2, 3, 2'b11, 0, 0, 32'h200), mk(OP_SUB, 4, 5, 6, 2'b11, 0, 0, 32'h204));
        idle("indep_iss", 1'b0);
        check("indep/pair", 64'(iss_valid), 64'd3);
        idle("indep_drain", 1'b0);

        pair_then_drain("raw", mk(OP_ADD, 5, 1, 2, 2'b11, 0, 0, 32'h300), mk(OP_SUB, 6, 5, 3, 2'b01, 0, 0, 32'h304));
        pair_then_drain("raw_x0", mk(OP_ADD, 0, 1, 2, 2'b11, 0, 0, 32'h310), mk(OP_SUB, 6, 0, 3, 2'b01, 0, 0, 32'h314));
        pair_then_drain("lw_add", mk(OP_ADD, 7, 1, 0, 2'b01, 1, 0, 32'h400), mk(OP_ADD, 8, 2, 3, 2'b11, 0, 0, 32'h404));
        pair_then_drain("beq_add", mk(OP_SUB, 0, 1, 2, 2'b11, 0, 1, 32'h410), mk(OP_ADD, 8, 2, 3, 2'b11, 0, 0, 32'h414));
        pair_then_drain("mul_div", mk(OP_MUL, 3, 1, 2, 2'b11, 0, 0, 32'h420), mk(OP_DIV, 4, 5, 6, 2'b11, 0, 0, 32'h424));
        pair_then_drain("add_lw", mk(OP_ADD, 3, 1, 2, 2'b11, 0, 0, 32'h430), mk(OP_ADD, 9, 4, 0, 2'b01, 1, 0, 32'h434));

        // Hold with backpressure, then drain in program order
        step("hold1", 2'b11, 1'b1, 1'b0, mk(OP_ADD, 1, 2, 3, 2'b11, 0, 0, 32'h500), mk(OP_MUL, 2, 1, 3, 2'b11, 0, 0, 32'h504));
        step("hold2", 2'b11, 1'b1, 1'b0, mk(OP_DIV, 3, 4, 5, 2'b11, 0, 0, 32'h508), mk(OP_ADD, 4, 3, 5, 2'b11, 0, 0, 32'h50c));
        step("hold3", 2'b11, 1'b1, 1'b0, mk(OP_SUB, 5, 6, 7, 2'b11, 0, 0, 32'h510), mk(OP_SUB, 6, 6, 7, 2'b11, 0, 0, 32'h514));
        idle("hold4", 1'b1);
        repeat (4) idle("hold_drain", 1'b0);

        // Flush beats a hold and a same-cycle decode pair
        step("pre_flush", 2'b11, 1'b0, 1'b0, mk(OP_ADD, 1, 2, 3, 2'b11, 0, 0, 32'h600), mk(OP_ADD, 2, 3, 4, 2'b11, 0, 0, 32'h604));
        step("pre_flush2", 2'b11, 1'b0, 1'b0, mk(OP_MUL, 3, 2, 3, 2'b11, 0, 0, 32'h608), mk(OP_DIV, 4, 3, 4, 2'b11, 0, 0, 32'h60c));
        step("flush", 2'b11, 1'b1, 1'b1, mk(OP_ADD, 7, 2, 3, 2'b11, 0, 0, 32'h610), mk(OP_ADD, 8, 3, 4, 2'b11, 0, 0, 32'h614));
        idle("post_flush", 1'b0);

        for (int i = 0; i < 5; i++) begin
            step("wrap", 2'b11, 1'b0, 1'b0,
                 mk(OP_ADD, 5'(2 * i + 1), 5'd20, 5'd21, 2'b11, 0, 0, 32'h700 + 32'(8 * i)),
                 mk(OP_SUB, 5'(2 * i + 2), 5'd22, 5'd23, 2'b11, 0, 0, 32'h704 + 32'(8 * i)));
        end
        repeat (3) idle("wrap_drain", 1'b0);

        for (int i = 0; i < 400; i++) begin
            int   r;
            logic [1:0] dv;
            r  = $urandom_range(0, 2);
            dv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            step("random", dv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                 rnd_ent(), rnd_ent());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
